// File: rtl/lane_sched_pkg.sv
// rtl/lane_sched_pkg.sv - shared types, sizes and helpers for the lane bank scheduler
package lane_sched_pkg;

  localparam int NUM_LANES  = 8;
  localparam int BANK_LANES = 4;

  typedef logic [2:0] lane_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_t;

  // Lane index to one-hot enable inside its bank (the bank itself goes on sel).
  function automatic logic [BANK_LANES-1:0] lane_to_en(input lane_id_t lane);
    return 4'b0001 << lane[1:0];
  endfunction

endpackage

// File: rtl/lane_bank_sched_rr_pick8.sv
// rtl/lane_bank_sched_rr_pick8.sv - rotating priority encoder over eight lane requests
module rr_pick8
  import lane_sched_pkg::*;
(
  input  logic [NUM_LANES-1:0] i_req,
  input  lane_id_t             i_ptr,
  output logic                 o_found,
  output lane_id_t             o_winner
);

  lane_id_t w_idx;

  // Walk the search order backwards so the lane closest to i_ptr is written last and wins.
  always_comb begin
    o_found  = 1'b0;
    o_winner = i_ptr;
    w_idx    = i_ptr;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      w_idx = i_ptr + lane_id_t'(i);
      if (i_req[w_idx]) begin
        o_found  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/lane_bank_sched.sv
// rtl/lane_bank_sched.sv - round-robin lane scheduler driving sel/en; LANE_BANK_SCHED_GAP_EN adds a dead cycle after each release
module lane_bank_sched
  import lane_sched_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_LANES-1:0]  i_req,
  output logic                  o_sel,
  output logic [BANK_LANES-1:0] o_en,
  output logic                  o_gnt_valid,
  output lane_id_t              o_gnt_id,
  output logic                  o_busy
);

  sched_state_t          r_state;
  lane_id_t              r_ptr;
  logic [7:0]            r_hold;
  logic                  r_sel;
  logic [BANK_LANES-1:0] r_en;
  logic                  r_gnt_valid;
  lane_id_t              r_gnt_id;

  sched_state_t          w_nxt_state;
  lane_id_t              w_nxt_ptr;
  logic [7:0]            w_nxt_hold;
  logic                  w_nxt_sel;
  logic [BANK_LANES-1:0] w_nxt_en;
  logic                  w_nxt_valid;
  lane_id_t              w_nxt_id;

  lane_id_t              w_pick_ptr;
  logic                  w_found;
  lane_id_t              w_winner;
  logic                  w_release;
  logic                  w_load;

  // During a grant the search already starts past the holder, so a still-requesting holder is found last.
  assign w_pick_ptr = (r_state == ST_GRANT) ? lane_id_t'(r_gnt_id + 3'd1) : r_ptr;

  assign w_release = (r_state == ST_GRANT) &&
                     (!i_req[r_gnt_id] || (r_hold == 8'(MAX_HOLD - 1)));

  rr_pick8 u_pick (
    .i_req    (i_req),
    .i_ptr    (w_pick_ptr),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  // Next-state and next-output decode; w_load marks an edge that starts a fresh grant.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_hold  = r_hold;
    w_nxt_sel   = r_sel;
    w_nxt_en    = r_en;
    w_nxt_valid = r_gnt_valid;
    w_nxt_id    = r_gnt_id;
    w_load      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_load = w_found;
      end
      ST_GRANT: begin
        if (w_release) begin
          w_nxt_ptr = r_gnt_id + 3'd1;
`ifdef LANE_BANK_SCHED_GAP_EN
          w_nxt_state = ST_GAP;
          w_nxt_en    = '0;
          w_nxt_valid = 1'b0;
`else
          if (w_found) begin
            w_load = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_en    = '0;
            w_nxt_valid = 1'b0;
          end
`endif
        end else begin
          w_nxt_hold = r_hold + 8'd1;
        end
      end
`ifdef LANE_BANK_SCHED_GAP_EN
      ST_GAP: begin
        if (w_found) begin
          w_load = 1'b1;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
`endif
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_en    = '0;
        w_nxt_valid = 1'b0;
      end
    endcase

    // sel only moves here, together with a new grant.
    if (w_load) begin
      w_nxt_state = ST_GRANT;
      w_nxt_hold  = 8'd0;
      w_nxt_sel   = w_winner[2];
      w_nxt_en    = lane_to_en(w_winner);
      w_nxt_valid = 1'b1;
      w_nxt_id    = w_winner;
    end
  end

  // State and output registers; reset clears any grant in flight immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_hold      <= '0;
      r_sel       <= 1'b0;
      r_en        <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_ptr       <= w_nxt_ptr;
      r_hold      <= w_nxt_hold;
      r_sel       <= w_nxt_sel;
      r_en        <= w_nxt_en;
      r_gnt_valid <= w_nxt_valid;
      r_gnt_id    <= w_nxt_id;
    end
  end

  assign o_sel       = r_sel;
  assign o_en        = r_en;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_id    = r_gnt_id;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lane_bank_sched.sv
// tb/tb_lane_bank_sched.sv - reference-model bench for lane_bank_sched (honours LANE_BANK_SCHED_GAP_EN)
module tb_lane_bank_sched;

  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] req1;

  logic       sel0, gv0, busy0;
  logic [3:0] en0;
  logic [2:0] id0;
  logic       sel1, gv1, busy1;
  logic [3:0] en1;
  logic [2:0] id1;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: who holds the lanes, for how long, where the search starts
  int m_holder;
  int m_held;
  int m_ptr;
  int m_last;
  bit m_gap;

  always #5 clk = ~clk;

  lane_bank_sched #(.MAX_HOLD(HOLD)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .o_sel(sel0), .o_en(en0), .o_gnt_valid(gv0), .o_gnt_id(id0), .o_busy(busy0)
  );

  lane_bank_sched #(.MAX_HOLD(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req1),
    .o_sel(sel1), .o_en(en1), .o_gnt_valid(gv1), .o_gnt_id(id1), .o_busy(busy1)
  );

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_held   = 0;
    m_ptr    = 0;
    m_last   = 0;
    m_gap    = 1'b0;
  endtask

  task automatic model_grant(input int w);
    m_holder = w;
    if (w >= 0) begin
      m_held = 1;
      m_last = w;
    end
  endtask

  task automatic model_edge();
    if (m_holder >= 0) begin
      if (!req[m_holder] || m_held == HOLD) begin
        m_ptr = (m_holder + 1) % 8;
`ifdef LANE_BANK_SCHED_GAP_EN
        m_holder = -1;
        m_gap    = 1'b1;
`else
        model_grant(pick(req, m_ptr));
`endif
      end else begin
        m_held++;
      end
    end else begin
      m_gap = 1'b0;
      model_grant(pick(req, m_ptr));
    end
  endtask

  task automatic check0(input string tag);
    logic [9:0] obs;
    logic [9:0] exp;
    logic [2:0] last3;
    logic [3:0] en_e;
    last3 = 3'(m_last);
    en_e  = (m_holder >= 0) ? 4'(1 << (m_holder % 4)) : 4'b0000;
    obs   = {sel0, en0, gv0, id0, busy0};
    exp   = {last3[2], en_e, (m_holder >= 0), last3, (m_holder >= 0) || m_gap};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s t=%0t {sel,en,valid,id,busy} observed=%b expected=%b", tag, $time, obs, exp);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check0(tag);
  endtask

  initial begin
    int lane;
    bit vld;

    // reset held with every lane requesting
    rst_n = 1'b0;
    req   = 8'hFF;
    req1  = 8'h11;
    model_reset();
    repeat (3) @(negedge clk);
    check0("reset");
    chk("reset_en", {28'd0, en0}, 32'd0);

    // fairness with all lanes requesting; MAX_HOLD=1 instance alternates 0/4 alongside
    rst_n = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      step("fair");
      if (k == 1) chk("first_grant", {27'd0, sel0, en0}, {27'd0, 1'b0, 4'b0001});
      if (k <= 12) begin
`ifdef LANE_BANK_SCHED_GAP_EN
        lane = (((k - 1) / 2) % 2 != 0) ? 4 : 0;
        vld  = (k % 2 == 1);
`else
        lane = (((k - 1) % 2) != 0) ? 4 : 0;
        vld  = 1'b1;
`endif
        chk("hold1_alt", {26'd0, sel1, en1, gv1},
            {26'd0, (lane == 4), (vld ? 4'b0001 : 4'b0000), vld});
      end
    end

    // single requester re-granted every window
    req = 8'h40;
    repeat (40) step("single");

    // early drop: lane 3 lets go while lane 5 waits
    req = 8'h00;
    repeat (3) step("idle");
    req = 8'h08;
    step("drop_grant3");
    chk("drop_id3", {29'd0, id0}, 32'd3);
    req = 8'h28;
    repeat (4) step("drop_hold");
    req = 8'h20;
    step("drop_edge");
`ifdef LANE_BANK_SCHED_GAP_EN
    chk("drop_gap", {28'd0, en0}, 32'd0);
    step("drop_edge2");
`endif
    chk("drop_lane5", {27'd0, sel0, en0}, {27'd0, 1'b1, 4'b0010});
    repeat (3) step("drop_after");

    // randomized request patterns, changed every few cycles
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: req = 8'($urandom);
          1: req = 8'($urandom & $urandom);
          default: req = 8'(1 << $urandom_range(0, 7));
        endcase
      end
      step("rand");
    end

    // asynchronous reset in the middle of a lane 7 grant
    req = 8'h00;
    repeat (2) step("pre7");
    req = 8'h80;
    step("grant7");
    chk("grant7_id", {29'd0, id0}, 32'd7);
    step("grant7_hold");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check0("async_rst");
    chk("async_en_gv", {27'd0, en0, gv0}, 32'd0);
    @(negedge clk);
    req   = 8'hFF;
    rst_n = 1'b1;
    step("post_rst");
    chk("post_rst_lane0", {29'd0, id0}, 32'd0);
    repeat (3) step("post_rst_run");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
